// File: rtl/spi_eeprom_pkg.sv
// Shared definitions for the M25AA010A transaction sequencer:
// EEPROM opcodes, FSM state encodings, status bit index and SPI frame fields.
package spi_eeprom_pkg;

    localparam logic [7:0] EE_READ  = 8'h03;
    localparam logic [7:0] EE_WRITE = 8'h02;
    localparam logic [7:0] EE_WREN  = 8'h06;
    localparam logic [7:0] EE_RDSR  = 8'h05;
    localparam logic [7:0] EE_WRDI  = 8'h04;

    // Write-in-progress bit of the RDSR status byte
    localparam int WIP = 0;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_WREN    = 4'd1;
    localparam logic [3:0] ST_W_WREN  = 4'd2;
    localparam logic [3:0] ST_WRITE   = 4'd3;
    localparam logic [3:0] ST_W_WRITE = 4'd4;
    localparam logic [3:0] ST_POLL    = 4'd5;
    localparam logic [3:0] ST_W_POLL  = 4'd6;
    localparam logic [3:0] ST_GAP     = 4'd7;
    localparam logic [3:0] ST_READ    = 4'd8;
    localparam logic [3:0] ST_W_READ  = 4'd9;
    localparam logic [3:0] ST_DONE    = 4'd10;

    // Fields handed to SPI_MASTER for one frame
    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [1:0] nbytes;
    } spi_frame_t;

    function automatic spi_frame_t mk_frame(input logic [7:0] instr, input logic [7:0] addr,
                                            input logic [7:0] wdata, input logic [1:0] nbytes);
        spi_frame_t f;
        f.instr  = instr;
        f.addr   = addr;
        f.wdata  = wdata;
        f.nbytes = nbytes;
        return f;
    endfunction

endpackage

// File: rtl/spi_poll_timer.sv
// Idle-gap down-counter between RDSR polls plus a saturating poll counter.
module spi_poll_timer #(
    parameter int POLL_GAP = 16,
    parameter int POLL_MAX = 1023
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,      // arm the gap counter for POLL_GAP clocks
    input  logic i_tick,      // one gap clock elapsed
    input  logic i_poll_clr,  // start of a new write: no polls yet
    input  logic i_poll_inc,  // one RDSR poll issued
    output logic o_gap_done,
    output logic o_poll_max
);

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int PW = $clog2(POLL_MAX + 1);

    logic [GW-1:0] r_gap;
    logic [PW-1:0] r_poll;

    // Gap counter: loaded with POLL_GAP-1 so the GAP state lasts exactly POLL_GAP clocks
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                   r_gap <= '0;
        else if (i_load)                r_gap <= GW'(POLL_GAP - 1);
        else if (i_tick && r_gap != '0) r_gap <= r_gap - 1'b1;
    end

    // Poll counter stops at POLL_MAX so it can never wrap back below the limit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                  r_poll <= '0;
        else if (i_poll_clr)                           r_poll <= '0;
        else if (i_poll_inc && r_poll != PW'(POLL_MAX)) r_poll <= r_poll + 1'b1;
    end

    assign o_gap_done = (r_gap == '0);
    assign o_poll_max = (r_poll == PW'(POLL_MAX));

endmodule

// File: rtl/spi_eeprom_sequencer.sv
// Byte read/write sequencer for the M25AA010A EEPROM behind SPI_MASTER.
// Writes run WREN, WRITE, then RDSR polls until WIP clears or the poll limit hits.
module spi_eeprom_sequencer import spi_eeprom_pkg::*; #(
    parameter int POLL_GAP = 16,
    parameter int POLL_MAX = 1023
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_we,
    input  logic [6:0] i_req_addr,
    input  logic [7:0] i_req_wdata,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_rdata,
    output logic       o_rsp_err,
    output logic       o_busy,
    output logic       o_spi_start,
    output logic [7:0] o_spi_instr,
    output logic [7:0] o_spi_addr,
    output logic [7:0] o_spi_wdata,
    output logic [1:0] o_spi_nbytes,
    input  logic       i_spi_done,
    input  logic [7:0] i_spi_rdata
);

    logic [3:0]  r_state;
    logic [6:0]  r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_spi_start;
    spi_frame_t  r_frame;

    logic w_gap_done;
    logic w_poll_max;
    logic w_gap_load;
    logic w_gap_tick;
    logic w_poll_clr;
    logic w_poll_inc;

    assign w_gap_load = (r_state == ST_W_POLL) && i_spi_done;
    assign w_gap_tick = (r_state == ST_GAP);
    assign w_poll_clr = (r_state == ST_W_WRITE) && i_spi_done;
    assign w_poll_inc = (r_state == ST_POLL);

    spi_poll_timer #(.POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_gap_load),
        .i_tick     (w_gap_tick),
        .i_poll_clr (w_poll_clr),
        .i_poll_inc (w_poll_inc),
        .o_gap_done (w_gap_done),
        .o_poll_max (w_poll_max)
    );

    // Transaction FSM; frame fields are only rewritten when a new frame is launched,
    // so they stay constant for the whole frame. spi_done in non-wait states is ignored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_spi_start <= 1'b0;
            r_frame     <= '0;
        end else begin
            r_spi_start <= 1'b0;
            case (r_state)
                ST_IDLE: if (i_req_valid) begin
                    r_addr  <= i_req_addr;
                    r_wdata <= i_req_wdata;
                    r_state <= i_req_we ? ST_WREN : ST_READ;
                end
                ST_WREN: begin
                    r_frame     <= mk_frame(EE_WREN, 8'h00, 8'h00, 2'd0);
                    r_spi_start <= 1'b1;
                    r_state     <= ST_W_WREN;
                end
                ST_W_WREN: if (i_spi_done) r_state <= ST_WRITE;
                ST_WRITE: begin
                    r_frame     <= mk_frame(EE_WRITE, {1'b0, r_addr}, r_wdata, 2'd2);
                    r_spi_start <= 1'b1;
                    r_state     <= ST_W_WRITE;
                end
                ST_W_WRITE: if (i_spi_done) r_state <= ST_POLL;
                ST_POLL: begin
                    r_frame     <= mk_frame(EE_RDSR, 8'h00, 8'h00, 2'd1);
                    r_spi_start <= 1'b1;
                    r_state     <= ST_W_POLL;
                end
                ST_W_POLL: if (i_spi_done) begin
                    if (!i_spi_rdata[WIP]) begin
                        r_rsp_rdata <= i_spi_rdata;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_DONE;
                    end else if (w_poll_max) begin
                        // Timed out: report the last (still busy) status byte
                        r_rsp_rdata <= i_spi_rdata;
                        r_rsp_err   <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: if (w_gap_done) r_state <= ST_POLL;
                ST_READ: begin
                    r_frame     <= mk_frame(EE_READ, {1'b0, r_addr}, 8'h00, 2'd2);
                    r_spi_start <= 1'b1;
                    r_state     <= ST_W_READ;
                end
                ST_W_READ: if (i_spi_done) begin
                    r_rsp_rdata <= i_spi_rdata;
                    r_rsp_err   <= 1'b0;
                    r_state     <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready  = (r_state == ST_IDLE);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_rsp_valid  = (r_state == ST_DONE);
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_rsp_err    = r_rsp_err;
    assign o_spi_start  = r_spi_start;
    assign o_spi_instr  = r_frame.instr;
    assign o_spi_addr   = r_frame.addr;
    assign o_spi_wdata  = r_frame.wdata;
    assign o_spi_nbytes = r_frame.nbytes;

endmodule

// File: tb/tb_spi_eeprom_sequencer.sv
// Bench for spi_eeprom_sequencer: frame-level EEPROM responder plus a reference
// model computing expected frames, status and read data from the command rules.
module tb_spi_eeprom_sequencer;
    import spi_eeprom_pkg::*;

    localparam int PG = 4;
    localparam int PM = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_we;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_err, busy;
    logic [7:0] rsp_rdata;
    logic       spi_start;
    logic [7:0] spi_instr, spi_addr, spi_wdata, spi_rdata;
    logic [1:0] spi_nbytes;
    logic       spi_done;
    logic       resp_done, stray_a, stray_b;

    assign spi_done = resp_done | stray_a | stray_b;

    always #1 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_eeprom_sequencer #(.POLL_GAP(PG), .POLL_MAX(PM)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_busy(busy),
        .o_spi_start(spi_start), .o_spi_instr(spi_instr), .o_spi_addr(spi_addr),
        .o_spi_wdata(spi_wdata), .o_spi_nbytes(spi_nbytes),
        .i_spi_done(spi_done), .i_spi_rdata(spi_rdata)
    );

    typedef struct {
        logic [7:0] instr, addr, wdata;
        logic [1:0] nb;
        int         t_start, t_done;
    } obs_t;

    // Written only by the responder
    obs_t       obs_q[$];
    logic [7:0] ee_mem[128];
    logic [7:0] inflight;
    int         ov_cnt;
    // Written only by the main sequence
    int         obs_rd = 0;
    int         cfg_busy;
    logic [7:0] busy_stat, done_stat;
    bit         stray_gap_en, hold_write;
    logic [7:0] ref_mem[128];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // EEPROM responder: answers each frame after a random delay using WEL/WIP rules
    initial begin : responder
        bit         wel;
        int         wip_left;
        resp_done = 1'b0; stray_b = 1'b0; spi_rdata = 8'h00;
        inflight = 8'h00; ov_cnt = 0; wel = 1'b0; wip_left = 0;
        for (int i = 0; i < 128; i++) ee_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (rst_n && spi_start) begin
                obs_t       o;
                int         dly;
                bit         ab;
                logic [7:0] rd;
                o.instr = spi_instr; o.addr = spi_addr; o.wdata = spi_wdata; o.nb = spi_nbytes;
                o.t_start = cyc; o.t_done = -1;
                inflight = spi_instr;
                dly = (hold_write && spi_instr == EE_WRITE) ? 20 : $urandom_range(1, 6);
                ab = 1'b0;
                for (int i = 0; i < dly; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin ab = 1'b1; break; end
                    if (spi_start || spi_instr !== o.instr || spi_addr !== o.addr ||
                        spi_wdata !== o.wdata || spi_nbytes !== o.nb) ov_cnt++;
                end
                inflight = 8'h00;
                if (!ab) begin
                    rd = 8'h00;
                    case (o.instr)
                        EE_WREN:  wel = 1'b1;
                        EE_WRITE: if (wel) begin
                            ee_mem[o.addr[6:0]] = o.wdata; wip_left = cfg_busy; wel = 1'b0;
                        end
                        EE_RDSR: begin
                            rd = (wip_left > 0) ? busy_stat : done_stat;
                            if (wip_left > 0) wip_left--;
                        end
                        EE_READ:  rd = ee_mem[o.addr[6:0]];
                        default: ;
                    endcase
                    spi_rdata = rd; resp_done = 1'b1; o.t_done = cyc; obs_q.push_back(o);
                    @(negedge clk);
                    resp_done = 1'b0;
                    if (stray_gap_en && o.instr == EE_RDSR && rd[0]) begin
                        stray_b = 1'b1;
                        @(negedge clk);
                        stray_b = 1'b0;
                    end
                end
            end
        end
    end

    // Call just after a negedge; returns one negedge after the accepting edge
    task automatic send(input bit we, input logic [6:0] a, input logic [7:0] d, output bit ok);
        int n = 0;
        req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        ok = req_ready;
        @(negedge clk);
    endtask

    task automatic wait_rsp(output bit ok);
        int n = 0;
        while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
        ok = rsp_valid;
    endtask

    task automatic check_frames(input bit we, input logic [6:0] a, input logic [7:0] d, input int npoll);
        int nexp, base;
        nexp = we ? 2 + npoll : 1;
        base = obs_rd;
        chk("frame_count", obs_q.size() - base, nexp);
        if (obs_q.size() - base == nexp) begin
            for (int i = 0; i < nexp; i++) begin
                obs_t o;
                o = obs_q[base + i];
                chk("addr_bit7", o.addr[7], 0);
                if (!we) begin
                    chk("rd_instr", o.instr, EE_READ); chk("rd_addr", o.addr, {1'b0, a}); chk("rd_nb", o.nb, 2);
                end else if (i == 0) begin
                    chk("wren_instr", o.instr, EE_WREN); chk("wren_nb", o.nb, 0);
                end else if (i == 1) begin
                    chk("wr_instr", o.instr, EE_WRITE); chk("wr_addr", o.addr, {1'b0, a});
                    chk("wr_data", o.wdata, d); chk("wr_nb", o.nb, 2);
                end else begin
                    chk("rdsr_instr", o.instr, EE_RDSR); chk("rdsr_nb", o.nb, 1);
                    if (i >= 3) chk("poll_gap", o.t_start - obs_q[base + i - 1].t_done, PG + 2);
                end
            end
        end
        obs_rd = obs_q.size();
    endtask

    task automatic do_req(input bit we, input logic [6:0] a, input logic [7:0] d, input int k);
        bit ok, ee;
        int np;
        logic [7:0] er;
        cfg_busy = k;
        if (we) begin
            np = (k < PM) ? k + 1 : PM;
            ee = (k >= PM);
            er = ee ? busy_stat : done_stat;
            ref_mem[a] = d;
        end else begin
            np = 0; ee = 1'b0; er = ref_mem[a];
        end
        @(negedge clk);
        send(we, a, d, ok);
        req_valid = 1'b0;
        chk("req_accepted", ok, 1);
        chk("busy_after_accept", busy, 1);
        chk("ready_low_busy", req_ready, 0);
        wait_rsp(ok);
        chk("rsp_seen", ok, 1);
        chk("rsp_rdata", rsp_rdata, er);
        chk("rsp_err", rsp_err, ee);
        check_frames(we, a, d, np);
        @(negedge clk);
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("ready_after_rsp", req_ready, 1);
    endtask

    initial begin : main
        bit ok;
        int n, ry;
        logic [7:0] bp_d;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        stray_a = 1'b0; stray_gap_en = 1'b0; hold_write = 1'b0;
        cfg_busy = 0; busy_stat = 8'h01; done_stat = 8'h00;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);   chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);   chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);         chk("rst_start", spi_start, 0);
        chk("rst_instr", spi_instr, 0);   chk("rst_addr", spi_addr, 0);
        chk("rst_wdata", spi_wdata, 0);   chk("rst_nbytes", spi_nbytes, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray spi_done while idle
        stray_a = 1'b1;
        @(negedge clk);
        stray_a = 1'b0;
        n = 0;
        repeat (6) begin @(negedge clk); if (spi_start || busy || !req_ready) n++; end
        chk("stray_idle", n, 0);

        // Directed write/read pairs
        busy_stat = 8'h03; done_stat = 8'h00;
        do_req(1'b1, 7'h15, 8'hA5, 0);
        do_req(1'b0, 7'h15, 8'h00, 0);
        do_req(1'b1, 7'h7F, 8'h3C, 2);
        do_req(1'b0, 7'h7F, 8'h00, 0);
        do_req(1'b0, 7'h00, 8'h00, 0);

        // Timeout with status stuck at 01h, stray spi_done inside each gap
        busy_stat = 8'h01; stray_gap_en = 1'b1;
        do_req(1'b1, 7'h20, 8'h55, 50);
        stray_gap_en = 1'b0;
        do_req(1'b0, 7'h20, 8'h00, 0);

        // Back-pressure: req_valid stays high; second request is a read of 00h
        busy_stat = 8'h81; done_stat = 8'h40; cfg_busy = 1; bp_d = 8'($urandom);
        ref_mem[7'h40] = bp_d;
        @(negedge clk);
        send(1'b1, 7'h40, bp_d, ok);
        chk("bp_accept", ok, 1);
        req_we = 1'b0; req_addr = 7'h00; req_wdata = 8'($urandom);
        n = 0; ry = 0;
        while (!rsp_valid && n < 3000) begin if (req_ready) ry++; @(negedge clk); n++; end
        chk("bp_rsp_seen", rsp_valid, 1);
        chk("bp_ready_held_low", ry, 0);
        chk("bp_wr_rdata", rsp_rdata, 8'h40);
        chk("bp_wr_err", rsp_err, 0);
        chk("bp_ready_in_done", req_ready, 0);
        check_frames(1'b1, 7'h40, bp_d, 2);
        @(negedge clk);
        chk("bp_ready_after_rsp", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_second_accepted", busy, 1);
        wait_rsp(ok);
        chk("bp_rd_seen", ok, 1);
        chk("bp_rd_rdata", rsp_rdata, ref_mem[0]);
        chk("bp_rd_err", rsp_err, 0);
        check_frames(1'b0, 7'h00, 8'h00, 0);
        @(negedge clk);

        // Reset in the middle of the WRITE frame
        hold_write = 1'b1; cfg_busy = 2;
        @(negedge clk);
        send(1'b1, 7'h33, 8'h99, ok);
        req_valid = 1'b0;
        n = 0;
        while (inflight != EE_WRITE && n < 200) begin @(negedge clk); n++; end
        chk("rst_mid_reached_write", inflight, EE_WRITE);
        @(posedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", req_ready, 1); chk("rst_mid_busy", busy, 0);
        chk("rst_mid_start", spi_start, 0); chk("rst_mid_rsp", rsp_valid, 0);
        chk("rst_mid_instr", spi_instr, 0); chk("rst_mid_nbytes", spi_nbytes, 0);
        @(negedge clk);
        rst_n = 1'b1; hold_write = 1'b0;
        obs_rd = obs_q.size();
        n = 0;
        repeat (20) begin @(negedge clk); if (rsp_valid || spi_start || busy) n++; end
        chk("rst_mid_quiet", n, 0);
        chk("rst_mid_ready_after", req_ready, 1);
        do_req(1'b0, 7'h33, 8'h00, 0);

        // Randomized traffic over a small address window
        for (int t = 0; t < 24; t++) begin
            busy_stat = 8'($urandom) | 8'h01;
            done_stat = 8'($urandom) & 8'hFE;
            do_req(1'($urandom_range(0, 1)), 7'($urandom_range(120, 127)), 8'($urandom),
                   $urandom_range(0, 4));
        end

        chk("no_frame_overlap", ov_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
